noc_packet_injector: RTL and testbench
======================================

Name: noc_packet_injector

Overview:
- Injection-side counterpart of the router's per-hop lookahead routing stage.
- Accepts a message request (multicast destination list, message type, body length) plus a stream of body payload words from a tile socket.
- Builds the header flit, computes the first-hop routing from the local router position, and streams header and body flits into the router local input port with valid/ready handshakes.

Parameters:
- DEST_SIZE, 6, number of multicast destination slots.
- FLIT_SIZE, 64, flit width in bits; must be >= 12 + DEST_SIZE*(1+$bits(noc::xy_t)).
- MAX_LEN, 16, maximum body flits per packet.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- position  in  $bits(noc::xy_t)  local router x,y; static after init.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted.
- req_dest  in  DEST_SIZE*$bits(noc::xy_t)  destination coordinates, noc::xy_t [0:DEST_SIZE-1].
- req_dest_val  in  DEST_SIZE  per-slot destination valid.
- req_msg  in  5  message type.
- req_len  in  LEN_W  body flit count, 0..MAX_LEN.
- data_in  in  FLIT_SIZE-2  body payload.
- data_in_valid  in  1  payload valid.
- data_in_ready  out  1  payload accepted.
- out_data  out  FLIT_SIZE  flit to router local input.
- out_valid  out  1  flit valid.
- out_ready  in  1  router can accept.
- len_err  out  1  sticky: a request had req_len > MAX_LEN.

Behaviour:
- Header flit layout, MSB first: head=1, tail, msg[4:0], dest_val[DEST_SIZE-1:0], dest list (slot 0 most significant), zero padding, routing[4:0] (noc::direction_t) in bits [4:0].
- Body flit layout: head=0, tail, payload[FLIT_SIZE-3:0].
- First-hop routing, per valid destination d (combinational over registered request fields):
  - d equal to position contributes 0.
  - Otherwise X first: goWest if position.x > d.x, goEast if position.x < d.x.
  - Else goNorth if position.y > d.y, goSouth if position.y < d.y.
  - Routing is the OR of all contributions. If the result is 0 (no remote valid destination, including all dest_val=0), routing = goLocal (loopback).
- FSM states: IDLE, HEADER, BODY. Reset state IDLE.
  - IDLE: req_ready=1, out_valid=0, data_in_ready=0. On req_valid: capture dest, dest_val, msg; len_q = min(req_len, MAX_LEN); set len_err if req_len > MAX_LEN; go to HEADER.
  - HEADER: out_valid=1, header flit held stable; tail = (len_q==0). On out_ready: if len_q==0 go to IDLE, else go to BODY with cnt=len_q.
  - BODY: out_valid=data_in_valid, data_in_ready=out_ready, out_data={0, cnt==1, data_in}. On each transfer cnt decrements; the transfer with cnt==1 returns to IDLE.
- Latency: header valid on the cycle after request acceptance. The next request can be accepted the cycle after the tail transfers.
- req_ready is 0 outside IDLE, so no overlapping packets.
- out_data and header fields must not change while out_valid=1 and out_ready=0.
- Reset values: req_ready=1 after release (IDLE); out_valid=0, data_in_ready=0, out_data=0, len_err=0, cnt=0.
- Asserting rst mid-packet aborts the packet immediately with no tail. Downstream recovery is outside this block.
- position is sampled combinationally; it must be stable from the request cycle to header transfer.

Optional Feature:
- Macro: NOC_PKT_INJ_SKID_EN.
- When defined:
  - A 2-entry skid buffer registers the output path for both header and body flits.
  - out_valid/out_data come from registers; data_in_ready depends only on buffer occupancy, not on out_ready.
  - Adds 1 cycle latency to every flit; full throughput is sustained.
- When undefined: combinational pass-through as above.

Test Plan:
- position=(2,2); one dest (4,1), len=0 -> single flit, head=1, tail=1, routing=goEast; req_ready back to 1 the cycle after transfer.
- position=(2,2); dests (2,0),(0,3),(2,2) valid, len=3 -> routing=goNorth|goWest|goLocal? No: (2,2) contributes 0, so routing=goNorth|goWest. Then 3 body flits, the last with tail=1.
- All dest_val=0, len=1 -> header routing=goLocal, one body flit with tail=1.
- len=4, out_ready toggling 1,0,0,1 and data_in_valid gaps -> out_data stable while stalled, exactly 4 body transfers, no flit duplicated or lost.
- req_len=MAX_LEN+3 -> len_err=1 sticky, exactly MAX_LEN body flits sent.
- rst asserted during BODY with cnt=2 -> out_valid=0 and req_ready=1 after release; the next request gives a correct header. With NOC_PKT_INJ_SKID_EN, a back-to-back stream runs at 1 flit/cycle after 1-cycle fill.

Source files
------------

// File: rtl/noc_packet_injector.sv
// Tile-side packet injector: builds the header flit with first-hop routing and streams header + body flits.
// Optional output skid buffer enabled by defining NOC_PKT_INJ_SKID_EN.
package noc;
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } xy_t;

  typedef logic [4:0] direction_t;

  localparam direction_t goNorth = 5'b00001;
  localparam direction_t goSouth = 5'b00010;
  localparam direction_t goWest  = 5'b00100;
  localparam direction_t goEast  = 5'b01000;
  localparam direction_t goLocal = 5'b10000;
endpackage

module noc_packet_injector #(
  parameter int DEST_SIZE = 6,
  parameter int FLIT_SIZE = 64,
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = $clog2(MAX_LEN+1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [$bits(noc::xy_t)-1:0]          position,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [DEST_SIZE*$bits(noc::xy_t)-1:0] req_dest,
  input  logic [DEST_SIZE-1:0]                 req_dest_val,
  input  logic [4:0]                           req_msg,
  input  logic [LEN_W-1:0]                     req_len,
  input  logic [FLIT_SIZE-3:0]                 data_in,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic [FLIT_SIZE-1:0]                 out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 len_err
);

  localparam int XY_W = $bits(noc::xy_t);
  localparam int DL_W = DEST_SIZE*XY_W;

  typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;

  state_t               state;
  logic                 req_ready_q;
  logic                 len_err_q;
  logic [DL_W-1:0]      dest_q;
  logic [DEST_SIZE-1:0] dest_val_q;
  logic [4:0]           msg_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     cnt;

  logic                 s_valid;
  logic                 s_ready;
  logic                 s_fire;
  logic [FLIT_SIZE-1:0] s_data;
  logic [FLIT_SIZE-1:0] hdr;

  noc::xy_t pos;
  assign pos = noc::xy_t'(position);

  // Per-destination first-hop contribution, X before Y; slot 0 sits in the MSBs of dest_q.
  logic [DEST_SIZE-1:0][4:0] lane_route;
  logic [4:0]                route_any;
  noc::direction_t           routing;

  for (genvar g = 0; g < DEST_SIZE; g++) begin : g_lane
    noc::xy_t   d;
    logic [4:0] r;
    assign d = noc::xy_t'(dest_q[(DEST_SIZE-1-g)*XY_W +: XY_W]);
    always_comb begin
      r = '0;
      if (dest_val_q[g] && (d != pos)) begin
        if (pos.x > d.x)      r = noc::goWest;
        else if (pos.x < d.x) r = noc::goEast;
        else if (pos.y > d.y) r = noc::goNorth;
        else                  r = noc::goSouth;
      end
    end
    assign lane_route[g] = r;
  end

  always_comb begin
    route_any = '0;
    for (int i = 0; i < DEST_SIZE; i++) route_any = route_any | lane_route[i];
    routing = (route_any == '0) ? noc::goLocal : route_any;
  end

  always_comb begin
    hdr = '0;
    hdr[FLIT_SIZE-1]                 = 1'b1;
    hdr[FLIT_SIZE-2]                 = (len_q == '0);
    hdr[FLIT_SIZE-3 -: 5]            = msg_q;
    hdr[FLIT_SIZE-8 -: DEST_SIZE]    = dest_val_q;
    hdr[FLIT_SIZE-8-DEST_SIZE -: DL_W] = dest_q;
    hdr[4:0]                         = routing;
  end

  always_comb begin
    s_valid = 1'b0;
    s_data  = '0;
    case (state)
      HEADER: begin
        s_valid = 1'b1;
        s_data  = hdr;
      end
      BODY: begin
        s_valid = data_in_valid;
        s_data  = {1'b0, (cnt == LEN_W'(1)), data_in};
      end
      default: ;
    endcase
  end

  assign s_fire        = s_valid && s_ready;
  assign data_in_ready = (state == BODY) && s_ready;
  assign req_ready     = req_ready_q;
  assign len_err       = len_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      len_err_q   <= 1'b0;
      dest_q      <= '0;
      dest_val_q  <= '0;
      msg_q       <= '0;
      len_q       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dest_q      <= req_dest;
            dest_val_q  <= req_dest_val;
            msg_q       <= req_msg;
            len_q       <= (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;
            if (req_len > LEN_W'(MAX_LEN)) len_err_q <= 1'b1;
            req_ready_q <= 1'b0;
            state       <= HEADER;
          end
        end
        HEADER: begin
          if (s_fire) begin
            if (len_q == '0) begin
              req_ready_q <= 1'b1;
              state       <= IDLE;
            end else begin
              cnt   <= len_q;
              state <= BODY;
            end
          end
        end
        BODY: begin
          if (s_fire) begin
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              req_ready_q <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef NOC_PKT_INJ_SKID_EN
  // Two entries let the buffer absorb one flit per cycle while acceptance looks only at occupancy.
  logic [1:0][FLIT_SIZE-1:0] sk_buf;
  logic                      sk_wr;
  logic                      sk_rd;
  logic [1:0]                sk_cnt;
  logic                      o_fire;

  assign s_ready   = (sk_cnt != 2'd2);
  assign out_valid = (sk_cnt != 2'd0);
  assign out_data  = sk_buf[sk_rd];
  assign o_fire    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sk_buf <= '0;
      sk_wr  <= 1'b0;
      sk_rd  <= 1'b0;
      sk_cnt <= 2'd0;
    end else begin
      if (s_fire) begin
        sk_buf[sk_wr] <= s_data;
        sk_wr         <= ~sk_wr;
      end
      if (o_fire) sk_rd <= ~sk_rd;
      sk_cnt <= sk_cnt + {1'b0, s_fire} - {1'b0, o_fire};
    end
  end
`else
  assign s_ready   = out_ready;
  assign out_valid = s_valid;
  assign out_data  = s_data;
`endif

endmodule

// File: tb/tb_noc_packet_injector.sv
// Scoreboard bench for noc_packet_injector: expected flits queued at stimulus time, popped on transfer.
module tb_noc_packet_injector;

  localparam int DEST_SIZE = 6;
  localparam int FLIT_SIZE = 64;
  localparam int MAX_LEN   = 16;
  localparam int LEN_W     = 5;
`ifdef NOC_PKT_INJ_SKID_EN
  localparam int HDR_LAT = 2;
`else
  localparam int HDR_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  position = 6'd0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [35:0] req_dest = '0;
  logic [5:0]  req_dest_val = '0;
  logic [4:0]  req_msg = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic [61:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        len_err;

  noc_packet_injector #(.DEST_SIZE(DEST_SIZE), .FLIT_SIZE(FLIT_SIZE), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .position(position),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest), .req_dest_val(req_dest_val),
    .req_msg(req_msg), .req_len(req_len),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_xfer = 0;
  int ready_mode = 0;
  int xcyc [$];
  logic [63:0] exp_q [$];
  logic        stall_prev = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_route(input logic [5:0] p, input logic [35:0] d, input logic [5:0] v);
    logic [4:0] r;
    logic [5:0] xy;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      xy = d[(5-i)*6 +: 6];
      if (v[i] && xy != p) begin
        if (p[5:3] > xy[5:3])      r = r | noc::goWest;
        else if (p[5:3] < xy[5:3]) r = r | noc::goEast;
        else if (p[2:0] > xy[2:0]) r = r | noc::goNorth;
        else                       r = r | noc::goSouth;
      end
    end
    return (r == '0) ? noc::goLocal : r;
  endfunction

  // Output-side monitor: scoreboard pop, stall stability, transfer timestamps.
  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_extra", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          chk("sb_flit", out_data, e);
        end
        n_xfer++;
        xcyc.push_back(cyc);
      end
    end
  end

  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       begin out_ready = pat[3 - (k % 4)]; k++; end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(n < 600), 64'd1);
  endtask

  task automatic send_pkt(input string tag, input logic [35:0] d, input logic [5:0] v, input logic [4:0] msg,
                          input int len, input logic [4:0] route, input int max_gap, input bit chk_tp);
    int eff, base;
    logic [61:0] pay [$];
    logic [63:0] r64;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    exp_q.push_back({1'b1, 1'(eff == 0), msg, v, d, 10'b0, route});
    for (int i = 0; i < eff; i++) begin
      r64 = {$urandom(), $urandom()};
      pay.push_back(r64[61:0]);
      exp_q.push_back({1'b0, 1'(i == eff-1), r64[61:0]});
    end
    base = n_xfer;
    @(posedge clk);
    #1;
    req_dest = d; req_dest_val = v; req_msg = msg; req_len = LEN_W'(len); req_valid = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      chk({tag, "_req_acc"}, req_ready, 1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    fork
      begin
        int lat;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        chk({tag, "_hdr_lat"}, lat, HDR_LAT);
      end
      begin
        int n2, gap;
        for (int i = 0; i < eff; i++) begin
          gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
          repeat (gap) begin data_in_valid = 1'b0; @(posedge clk); #1; end
          data_in = pay[i];
          data_in_valid = 1'b1;
          n2 = 0;
          @(negedge clk);
          while (!data_in_ready && n2 < 200) begin @(negedge clk); n2++; end
          chk({tag, "_din"}, data_in_ready, 1);
          @(posedge clk);
          #1;
        end
        data_in_valid = 1'b0;
      end
    join
    wait_done(tag);
    chk({tag, "_nflits"}, n_xfer - base, eff + 1);
    if (chk_tp && n_xfer > base) chk({tag, "_span"}, xcyc[n_xfer-1] - xcyc[base], eff);
  endtask

  initial begin
    logic [63:0] r64;
    logic [35:0] d1, d2, dr;
    position = {3'd2, 3'd2};
    d1 = {3'd4, 3'd1, 30'b0};
    d2 = {3'd2, 3'd0, 3'd0, 3'd3, 3'd2, 3'd2, 18'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_din_ready", data_in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_len_err", len_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    send_pkt("t1_east_len0", d1, 6'b000001, 5'h03, 0, noc::goEast, 0, 1);
    send_pkt("t2_nw_len3", d2, 6'b000111, 5'h0a, 3, noc::goNorth | noc::goWest, 0, 1);
    r64 = {$urandom(), $urandom()};
    send_pkt("t3_loopback", r64[35:0], 6'b000000, 5'h11, 1, noc::goLocal, 0, 1);
    chk("len_err_clear", len_err, 0);

    ready_mode = 1;
    send_pkt("t4_stall", d1, 6'b000001, 5'h04, 4, noc::goEast, 2, 0);
    ready_mode = 0;

    send_pkt("t5_overlen", d2, 6'b000111, 5'h1f, MAX_LEN + 3, noc::goNorth | noc::goWest, 0, 1);
    chk("len_err_set", len_err, 1);

    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      r64 = {$urandom(), $urandom()};
      dr = r64[35:0];
      send_pkt("rnd", dr, r64[41:36], r64[46:42], $urandom_range(0, 6), model_route(position, dr, r64[41:36]), 1, 0);
    end
    ready_mode = 0;
    chk("len_err_sticky", len_err, 1);

    // Abort mid-body: header and first body flit out, cnt left at 2.
    exp_q.push_back({1'b1, 1'b0, 5'h05, 6'b000001, d1, 10'b0, noc::goEast});
    r64 = {$urandom(), $urandom()};
    exp_q.push_back({1'b0, 1'b0, r64[61:0]});
    @(posedge clk);
    #1;
    req_dest = d1; req_dest_val = 6'b000001; req_msg = 5'h05; req_len = 5'd3; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    data_in = r64[61:0];
    data_in_valid = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!data_in_ready && n < 50) begin @(negedge clk); n++; end
      chk("abort_din", data_in_ready, 1);
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
      chk("abort_drain", 64'(exp_q.size()), 64'd0);
    end
    chk("abort_in_body", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_in_valid = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_din_ready", data_in_ready, 0);
    chk("abort_len_err", len_err, 0);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_req_ready", req_ready, 1);

    send_pkt("t7_south", {3'd2, 3'd4, 30'b0}, 6'b000001, 5'h07, 2, noc::goSouth, 0, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    chk("watchdog_cycles", 64'(cyc), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
